prog_loader: RTL

- Writable program store for the 4-bit CPU; it replaces a fixed instruction ROM.
- A host byte stream (valid/ready) fills a 16x8 program RAM, then a checksum byte is checked.
- The CPU is held in reset while loading and released only after a good checksum.
- The CPU fetches combinationally from the same RAM through the existing 4-bit address / 8-bit data instruction interface.

---
 rtl/prog_loader_pkg.sv | 19 +
 rtl/prog_loader_ram.sv | 38 +++
 rtl/prog_loader.sv | 125 ++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_defs: shared definitions for the program loader slice.
//   - AW_DEF / DW_DEF : default address / instruction widths
//   - state_e         : loader FSM state encoding
// ---------------------------------------------------------------------------
package loader_defs;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

endpackage : loader_defs

// File: rtl/prog_loader_ram.sv
// ---------------------------------------------------------------------------
// prog_ram: 2**AW x DW program store.
//   clk, n_reset : clock, asynchronous active-low clear of every word
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : asynchronous (combinational) read port
// The asynchronous clear rules out a block RAM, so the store is a plain
// register array.
// ---------------------------------------------------------------------------
module prog_ram
  import loader_defs::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DEPTH-1:0][DW-1:0] mem_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mem_q <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : prog_ram

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader: writable program store for the 4-bit CPU.
//   clk, n_reset          : clock, asynchronous active-low reset
//   load_start            : pulse, begins/restarts a program load
//   rx_data/valid/ready   : host byte stream (2**AW words, then checksum)
//   cpu_addr, cpu_data    : CPU instruction fetch (combinational read)
//   cpu_n_reset           : registered active-low CPU reset
//   busy                  : loading or waiting for checksum
//   load_ok, load_err     : outcome of the last completed load
// ---------------------------------------------------------------------------
module prog_loader
  import loader_defs::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          load_start,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [AW-1:0] cpu_addr,
  output logic [DW-1:0] cpu_data,
  output logic          cpu_n_reset,
  output logic          busy,
  output logic          load_ok,
  output logic          load_err
);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DW-1:0] sum_q, sum_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic          cpu_n_reset_q, cpu_n_reset_d;
  logic          we;
  logic          accept;
  logic [DW-1:0] sum_plus;

  assign rx_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign busy     = rx_ready;
  assign accept   = rx_valid && rx_ready;
  assign sum_plus = sum_q + rx_data;   // DW-bit wrap is the checksum modulus

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    sum_d         = sum_q;
    ok_d          = ok_q;
    err_d         = err_q;
    cpu_n_reset_d = cpu_n_reset_q;
    we            = 1'b0;

    if (load_start) begin
      // Restart from any state; a byte arriving on this edge is dropped.
      state_d       = ST_LOAD;
      wr_ptr_d      = '0;
      sum_d         = '0;
      ok_d          = 1'b0;
      err_d         = 1'b0;
      cpu_n_reset_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (accept) begin
            we       = 1'b1;
            sum_d    = sum_plus;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == {AW{1'b1}}) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (accept) begin
            if (sum_plus == '0) begin
              state_d       = ST_RUN;
              ok_d          = 1'b1;
              cpu_n_reset_d = 1'b1;
            end else begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
            end
          end
        end
        default: ;  // IDLE, RUN, ERROR hold until load_start
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      sum_q         <= '0;
      ok_q          <= 1'b0;
      err_q         <= 1'b0;
      cpu_n_reset_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      sum_q         <= sum_d;
      ok_q          <= ok_d;
      err_q         <= err_d;
      cpu_n_reset_q <= cpu_n_reset_d;
    end
  end

  assign load_ok     = ok_q;
  assign load_err    = err_q;
  assign cpu_n_reset = cpu_n_reset_q;

  prog_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk    (clk),
    .n_reset(n_reset),
    .we     (we),
    .waddr  (wr_ptr_q),
    .wdata  (rx_data),
    .raddr  (cpu_addr),
    .rdata  (cpu_data)
  );

endmodule : prog_loader
